mem_arbiter: RTL

Two-port arbiter that shares the single external memory port (memread/memwrite/adr/writedata/memdata) between the cellspu core and a secondary requester (DMA / program loader). It serializes accesses one transaction at a time, grants round-robin on contention, and returns read data and a one-cycle acknowledge to the winning requester. It sits between the requesters and exmemory inside the top-level design.

---
 rtl/mem_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between two requesters.
// Serialises one transaction at a time: IDLE -> ACC -> (WAIT for reads) -> RESP -> IDLE.
module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             ack0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             req1,
    input  logic             we1,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata1,
    output logic             memread,
    output logic             memwrite,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] memdata,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   sel;
    logic   we_r;
    logic   grant;
    logic   grant_sel;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        grant     = req0 | req1;
        grant_sel = (req0 & req1) ? ~last : req1;
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACC;
            ACC:     state_nxt = we_r ? RESP : WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last      <= 1'b1;
            sel       <= 1'b0;
            we_r      <= 1'b0;
            adr       <= '0;
            writedata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            if (state == IDLE && grant) begin
                sel       <= grant_sel;
                last      <= grant_sel;
                we_r      <= grant_sel ? we1 : we0;
                adr       <= grant_sel ? adr1 : adr0;
                writedata <= grant_sel ? wdata1 : wdata0;
            end
            // Memory returns read data during the cycle after the strobe.
            if (state == WAIT) begin
                if (sel) begin
                    rdata1 <= memdata;
                end else begin
                    rdata0 <= memdata;
                end
            end
        end
    end

    assign memread  = (state == ACC) & ~we_r;
    assign memwrite = (state == ACC) & we_r;
    assign ack0     = (state == RESP) & ~sel;
    assign ack1     = (state == RESP) & sel;
    assign busy     = (state != IDLE);

endmodule
